// File: rtl/reg_master.sv
// Register-bus master: takes one command at a time, drives a start/end framed
// register access, waits for read data with a bounded timeout, and returns a response.
module reg_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       sys_clk_25m,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_rw,
  output logic       reg_rw_start,
  output logic       reg_rw_end,
  input  logic [7:0] reg_rd_data,
  input  logic       reg_out_oe,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, WAIT_OE, END, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] addr_d, wdata_d, rdata_d;
  logic       rw_d, err_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = reg_addr;
    wdata_d = reg_wr_data;
    rw_d    = reg_rw;
    rdata_d = rsp_rdata;
    err_d   = rsp_err;
    case (state)
      IDLE: begin
        // cmd_ready is low for the first cycle out of reset, so it gates the handshake
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          rw_d    = cmd_rw;
          rdata_d = 8'h00;
          err_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (reg_rw) begin
          cnt_d   = 8'h00;
          state_d = WAIT_OE;
        end else begin
          state_d = END;
        end
      end
      WAIT_OE: begin
        // data on the terminal-count cycle still wins over the timeout
        if (reg_out_oe) begin
          rdata_d = reg_rd_data;
          err_d   = 1'b0;
          state_d = END;
        end else if (cnt == LAST_WAIT) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = END;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      END:  state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a flop loaded from the next-state decode.
  always_ff @(posedge sys_clk_25m or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      cnt          <= 8'h00;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      reg_addr     <= 8'h00;
      reg_wr_data  <= 8'h00;
      reg_rw       <= 1'b0;
      reg_rw_start <= 1'b0;
      reg_rw_end   <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      reg_addr     <= addr_d;
      reg_wr_data  <= wdata_d;
      reg_rw       <= rw_d;
      rsp_rdata    <= rdata_d;
      rsp_err      <= err_d;
      cmd_ready    <= (state_d == IDLE);
      busy         <= (state_d != IDLE);
      reg_rw_start <= (state_d == START);
      reg_rw_end   <= (state_d == END);
      rsp_valid    <= (state_d == RESP);
    end
  end

endmodule

// File: tb/tb_reg_master.sv
// Self-checking bench for reg_master: directed vector table, hand-written
// backpressure/reset sequences, and random commands against a memory model.
module tb_reg_master;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
  logic       reg_rw, reg_rw_start, reg_rw_end, reg_out_oe, busy;

  reg_master #(.TIMEOUT_CYCLES(TO)) dut (
    .sys_clk_25m(clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_rw(reg_rw),
    .reg_rw_start(reg_rw_start), .reg_rw_end(reg_rw_end),
    .reg_rd_data(reg_rd_data), .reg_out_oe(reg_out_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  // Responder: register file, oe raised in the oe_delay-th cycle after start (0 = never).
  logic [7:0] bus_mem [256];
  int oe_delay = 0;
  int rem = 0;
  bit pend = 0;
  initial begin
    for (int i = 0; i < 256; i++) bus_mem[i] = 8'h00;
    reg_out_oe = 1'b0;
    reg_rd_data = 8'h00;
  end
  always @(negedge clk) begin
    reg_out_oe = 1'b0;
    reg_rd_data = 8'($urandom);
    if (sys_rst) begin
      pend = 0;
    end else if (reg_rw_start) begin
      if (!reg_rw) bus_mem[reg_addr] = reg_wr_data;
      else begin pend = (oe_delay > 0); rem = oe_delay; end
    end else if (reg_rw_end) begin
      pend = 0;
    end else if (pend) begin
      rem--;
      if (rem == 0) begin
        reg_out_oe = 1'b1;
        reg_rd_data = bus_mem[reg_addr];
        pend = 0;
      end
    end
  end

  int overlap = 0, end_cnt = 0, rsp_cnt = 0;
  always @(negedge clk) begin
    if (reg_rw_start && reg_rw_end) overlap++;
    if (reg_rw_end) end_cnt++;
    if (rsp_valid) rsp_cnt++;
  end

  // Reference model: what the register file should hold, and the rules for each response.
  logic [7:0] model_mem [256];

  typedef struct {
    bit         rw;
    logic [7:0] addr, wdata;
    int         delay, hold;
    logic [7:0] exp_rdata;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  int last_wait;

  // Called at a negedge; returns at the negedge right after the response handshake.
  task automatic run_cmd(input vec_t v, input string nm);
    int c, wt, st_c, en_c, nst, nen;
    logic [7:0] r0;
    logic e0;
    oe_delay  = v.delay;
    rsp_ready = (v.hold == 0);
    cmd_valid = 1'b1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_wdata = v.wdata;
    wt = 0;
    while (!cmd_ready && wt < 50) begin @(negedge clk); wt++; end
    last_wait = wt;
    if (wt >= 50) chk({nm, "_accept_timeout"}, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_rw = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    c = 1; st_c = 0; en_c = 0; nst = 0; nen = 0;
    while (!rsp_valid && c < 100) begin
      if (reg_rw_start) begin nst++; st_c = c; end
      if (reg_rw_end) begin nen++; en_c = c; end
      if (c == 1) chk({nm, "_bus_req"}, {reg_rw, reg_addr, reg_wr_data, cmd_ready},
                      {v.rw, v.addr, v.wdata, 1'b0});
      @(negedge clk); c++;
    end
    chk({nm, "_latency"}, c, v.exp_lat);
    chk({nm, "_start_pulse"}, {st_c[15:0], nst[15:0]}, {16'd1, 16'd1});
    chk({nm, "_end_pulse"}, {en_c[15:0], nen[15:0]}, {16'(c - 1), 16'd1});
    chk({nm, "_rsp"}, {rsp_err, rsp_rdata}, {v.exp_err, v.exp_rdata});
    chk({nm, "_rsp_state"}, {busy, cmd_ready, reg_addr}, {1'b1, 1'b0, v.addr});
    r0 = rsp_rdata; e0 = rsp_err;
    if (v.hold > 0) begin
      for (int i = 0; i < v.hold; i++) begin
        cmd_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_hold"}, {rsp_valid, cmd_ready, rsp_err, rsp_rdata, reg_addr},
            {1'b1, 1'b0, e0, r0, v.addr});
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk({nm, "_done"}, {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  function automatic vec_t model_cmd(input bit rw, input logic [7:0] a, w, input int d, h);
    vec_t v;
    v.rw = rw; v.addr = a; v.wdata = w; v.delay = d; v.hold = h;
    if (!rw) begin
      model_mem[a] = w;
      v.exp_rdata = 8'h00; v.exp_err = 1'b0; v.exp_lat = 3;
    end else if (d >= 1 && d <= TO) begin
      v.exp_rdata = model_mem[a]; v.exp_err = 1'b0; v.exp_lat = 3 + d;
    end else begin
      v.exp_rdata = 8'h00; v.exp_err = 1'b1; v.exp_lat = 3 + TO;
    end
    return v;
  endfunction

  vec_t tbl [10];
  int e_before, r_before;

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    //            rw  addr   wdata  dly hold rdata  err lat
    tbl[0] = '{1'b0, 8'h10, 8'h5A, 0,  0, 8'h00, 1'b0, 3};
    tbl[1] = '{1'b1, 8'h10, 8'h77, 1,  0, 8'h5A, 1'b0, 4};
    tbl[2] = '{1'b0, 8'h10, 8'hA5, 0,  0, 8'h00, 1'b0, 3};
    tbl[3] = '{1'b1, 8'h10, 8'h00, 1,  0, 8'hA5, 1'b0, 4};
    tbl[4] = '{1'b1, 8'h10, 8'h00, 0,  0, 8'h00, 1'b1, 19};
    tbl[5] = '{1'b1, 8'h10, 8'h00, 16, 0, 8'hA5, 1'b0, 19};
    tbl[6] = '{1'b1, 8'h10, 8'h00, 17, 0, 8'h00, 1'b1, 19};
    tbl[7] = '{1'b0, 8'h20, 8'h3C, 0,  5, 8'h00, 1'b0, 3};
    tbl[8] = '{1'b1, 8'h20, 8'h00, 3,  2, 8'h3C, 1'b0, 6};
    tbl[9] = '{1'b1, 8'h20, 8'hFF, 2,  0, 8'h3C, 1'b0, 5};

    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b0;
    #12;
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, reg_addr,
                          reg_wr_data, reg_rw, reg_rw_start, reg_rw_end}, 0);
    @(negedge clk); @(negedge clk);
    sys_rst = 1'b0;
    chk("ready_before_edge", cmd_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_release", {cmd_ready, busy}, 2'b10);

    for (int i = 0; i < 10; i++) begin
      if (!tbl[i].rw) model_mem[tbl[i].addr] = tbl[i].wdata;
      run_cmd(tbl[i], $sformatf("vec%0d", i));
    end
    // Commands held during backpressure in vec8 must not be taken; next one goes at once.
    chk("vec9_no_wait", last_wait, 0);

    // Back-to-back writes with rsp_ready high: accepted every 4 cycles.
    for (int i = 0; i < 3; i++) begin
      run_cmd(model_cmd(1'b0, 8'(8'h30 + i), 8'(8'hC0 + i), 0, 0), $sformatf("b2b%0d", i));
      chk($sformatf("b2b%0d_wait", i), last_wait, 0);
    end

    // Reset in the middle of a read wait: aborts with no end pulse and no response.
    oe_delay = 0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'h30; cmd_wdata = 8'h00;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", {busy, reg_rw_start, reg_rw_end, rsp_valid}, 4'b1000);
    e_before = end_cnt; r_before = rsp_cnt;
    #2 sys_rst = 1'b1;
    #1;
    chk("mid_reset_async", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, reg_addr,
                            reg_wr_data, reg_rw, reg_rw_start, reg_rw_end}, 0);
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    chk("mid_ready_before_edge", cmd_ready, 1'b0);
    @(negedge clk);
    chk("mid_ready_after_release", cmd_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("mid_no_end_no_rsp", {end_cnt - e_before, rsp_cnt - r_before}, 0);

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_cmd(model_cmd(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom),
                        int'($urandom_range(0, 18)), int'($urandom_range(0, 3))),
              $sformatf("rnd%0d", i));
    end

    chk("start_end_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_master.md
REG_MASTER -- requirements
Module: reg_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of read-wait cycles before abort (range 2..255).
REQ-002 The block SHALL have port sys_clk_25m, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_rw (input, 1, 1=read, 0=write), cmd_addr (input, 8) and cmd_wdata (input, 8): the upstream command channel.
REQ-005 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 8) and rsp_err (output, 1, 1=read timeout): the upstream response channel.
REQ-006 The block SHALL have ports reg_addr (output, 8), reg_wr_data (output, 8), reg_rw (output, 1), reg_rw_start (output, 1) and reg_rw_end (output, 1): the register-bus request to the responder.
REQ-007 The block SHALL have ports reg_rd_data (input, 8) and reg_out_oe (input, 1): the read data and data-valid signals from the responder.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 The block SHALL implement an FSM with states IDLE, START, WAIT_OE, END and RESP; all outputs are registered.
REQ-010 In IDLE, the block SHALL hold cmd_ready=1; when cmd_valid=1 it latches cmd_rw, cmd_addr and cmd_wdata and moves to START (the handshake is cmd_valid & cmd_ready on one edge).
REQ-011 In all states other than IDLE, the block SHALL hold cmd_ready=0 and ignore cmd_valid; commands are not queued.
REQ-012 In START, the block SHALL assert reg_rw_start for exactly one cycle, with reg_addr, reg_wr_data and reg_rw equal to the latched command.
REQ-013 The block SHALL keep reg_addr, reg_wr_data and reg_rw stable from START until the next command is accepted.
REQ-014 From START, a write SHALL go to END, and a read SHALL go to WAIT_OE with an 8-bit wait counter cleared to 0.
REQ-015 In WAIT_OE with reg_out_oe=1, the block SHALL capture reg_rd_data into rsp_rdata, set rsp_err=0 and go to END.
REQ-016 In WAIT_OE with reg_out_oe=0, the block SHALL increment the counter; when the counter equals TIMEOUT_CYCLES-1, it sets rsp_rdata=8'h00 and rsp_err=1 and goes to END.
REQ-017 If reg_out_oe=1 on the terminal count cycle, the block SHALL treat the read as a success (capture the data, rsp_err=0).
REQ-018 Writes SHALL never sample reg_out_oe; a write completes with rsp_rdata=8'h00 and rsp_err=0.
REQ-019 In END, the block SHALL assert reg_rw_end for exactly one cycle and then go to RESP.
REQ-020 In RESP, the block SHALL hold rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready=1; on that edge rsp_valid drops and the state returns to IDLE.
REQ-021 If rsp_ready is already high when RESP is entered, the response SHALL last exactly one cycle.
REQ-022 Latency, with cmd accepted at edge T:
- write: reg_rw_start high in cycle T+1, reg_rw_end in T+2, rsp_valid from T+3;
- read where oe is seen in the first WAIT_OE cycle: start T+1, sample T+2, end T+3, rsp_valid T+4;
- read timeout: rsp_valid from T+3+TIMEOUT_CYCLES.
REQ-023 The earliest next command acceptance SHALL be one cycle after rsp handshake (back-to-back throughput: write 4 cycles with rsp_ready held high).
REQ-024 reg_rw_start and reg_rw_end SHALL never be high in the same cycle.

Reset
REQ-025 While sys_rst=1, the block SHALL immediately force the state to IDLE, clear the wait counter, and set outputs as follows:
- cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0;
- reg_addr=0, reg_wr_data=0, reg_rw=0, reg_rw_start=0, reg_rw_end=0.
REQ-026 On the first edge after sys_rst falls, the block SHALL set cmd_ready=1.
REQ-027 A reset asserted mid-transaction SHALL abort it with no reg_rw_end pulse and no response.

Verification
REQ-028 Write 8'h5A to address 8'h10 against a responder model -> start T+1, end T+2, rsp_valid T+3 with rsp_err=0; a following read of 8'h10 returns 8'h5A.
REQ-029 Read of 8'h10 where the model raises oe one cycle after start with data 8'hA5 -> rsp_rdata=8'hA5, rsp_err=0, rsp_valid at T+4.
REQ-030 Read with oe tied low and TIMEOUT_CYCLES=16 -> exactly 16 WAIT_OE cycles, then one reg_rw_end pulse, rsp_rdata=8'h00 and rsp_err=1.
REQ-031 Hold rsp_ready low for 5 cycles while a second cmd_valid is held -> rsp fields stay stable, cmd_ready stays 0, the second command is accepted only after the handshake.
REQ-032 Assert sys_rst during WAIT_OE -> all outputs reach their reset values asynchronously, no reg_rw_end pulse occurs, and cmd_ready=1 one edge after release.
